// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction ROM address from the PC and captures the
// returned word into the IF/ID register, with stall, branch redirect/squash and a debug fetch counter.
module instruction_fetch #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [7:0]  BRANCH_TARGET,
    input  logic [31:0] IMEM_RD,
    output logic [7:0]  IMEM_A,
    output logic [7:0]  PC,
    output logic [31:0] INSTR,
    output logic [7:0]  INSTR_PC,
    output logic        INSTR_VALID,
    output logic [15:0] FETCH_COUNT
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_instr_pc;
    logic        r_instr_valid;
    logic [15:0] r_fetch_count;

    state_t      w_state_next;
    logic [7:0]  w_pc_next;
    logic [31:0] w_instr_next;
    logic [7:0]  w_instr_pc_next;
    logic        w_instr_valid_next;
    logic [15:0] w_fetch_count_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_WORD;
            r_instr_pc    <= 8'h00;
            r_instr_valid <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    // Branch outranks stall: the wrong-path word must be squashed even when the
    // decoder is holding, otherwise it would re-issue after the stall releases.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;
        w_fetch_count_next = r_fetch_count;

        case (r_state)
            S_BOOT: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (BRANCH_TAKEN) begin
                    w_pc_next          = {BRANCH_TARGET[7:2], 2'b00};
                    w_instr_next       = NOP_WORD;
                    w_instr_valid_next = 1'b0;
                end else if (!STALL) begin
                    w_pc_next          = r_pc + 8'd4;
                    w_instr_next       = IMEM_RD;
                    w_instr_pc_next    = r_pc;
                    w_instr_valid_next = 1'b1;
                    if (r_fetch_count != '1) begin
                        w_fetch_count_next = r_fetch_count + 16'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    assign IMEM_A      = r_pc;
    assign PC          = r_pc;
    assign INSTR       = r_instr;
    assign INSTR_PC    = r_instr_pc;
    assign INSTR_VALID = r_instr_valid;
    assign FETCH_COUNT = r_fetch_count;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that drives the 8-bit address input of the combinational instruction ROM and captures its 32-bit output into an IF/ID pipeline register for the decoder. Holds the program counter, advances it by 4 per accepted fetch, and redirects it on branches resolved downstream. Supports pipeline stall, branch squash and a saturating retired-fetch counter for debug.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset (bits [1:0] must be 0)
- NOP_WORD, 32'h00000013, value loaded into INSTR when squashed or reset

- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- STALL  in  1  hold PC and IF/ID register
- BRANCH_TAKEN  in  1  redirect PC this cycle
- BRANCH_TARGET  in  8  byte address of redirect target
- IMEM_RD  in  32  instruction word from ROM (combinational from IMEM_A)
- IMEM_A  out  8  ROM address, equals PC combinationally
- PC  out  8  current fetch address
- INSTR  out  32  IF/ID instruction register
- INSTR_PC  out  8  address INSTR was fetched from
- INSTR_VALID  out  1  INSTR holds a real fetched instruction
- FETCH_COUNT  out  16  number of valid instructions captured, saturating

## Operation
- Reset (RST=1 at edge): PC=RESET_PC, INSTR=NOP_WORD, INSTR_PC=8'h00, INSTR_VALID=0, FETCH_COUNT=0, state=BOOT. RST overrides all other inputs.
- FSM states: BOOT, RUN.
  - BOOT: one bubble cycle; PC, IF/ID unchanged; next state RUN unconditionally (ignores STALL, BRANCH_TAKEN).
  - RUN: per-edge priority BRANCH_TAKEN > STALL > normal fetch.
- Normal fetch (RUN, !STALL, !BRANCH_TAKEN): INSTR<=IMEM_RD, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+4, FETCH_COUNT+=1.
- Stall (RUN, STALL, !BRANCH_TAKEN): PC, INSTR, INSTR_PC, INSTR_VALID, FETCH_COUNT hold.
- Branch (RUN, BRANCH_TAKEN, any STALL): PC<={BRANCH_TARGET[7:2],2'b00}; INSTR<=NOP_WORD, INSTR_VALID<=0 (squash wrong-path word); INSTR_PC holds; FETCH_COUNT holds.
- Arithmetic: PC+4 is 8-bit modulo; 8'hFC -> 8'h00. BRANCH_TARGET low two bits silently dropped. FETCH_COUNT saturates at 16'hFFFF.
- IMEM_A = PC at all times, including during BOOT and stall.

## Timing
- IMEM_A to IMEM_RD path is combinational; word is sampled at the same edge PC advances.
- Fetch latency: instruction at address X appears on INSTR one edge after PC==X in RUN without stall.
- Branch penalty: one invalid INSTR cycle after the redirect edge; target word appears on INSTR the following edge.
- After RST deasserts: edge 1 = BOOT->RUN (INSTR_VALID=0), edge 2 = first capture of word at RESET_PC.
- RST asserted mid-stream (including during stall or branch) takes effect at the next edge, discarding in-flight INSTR.
- STALL and BRANCH_TAKEN together: branch wins; downstream must not raise BRANCH_TAKEN for a squashed instruction.

## Test plan
- Reset then free run with ROM program 2: INSTR_VALID=0 for 2 edges, then INSTR=32'h0FF00083 @INSTR_PC 0x00, 32'h00100113 @0x04, 32'h0020F1B3 @0x08; FETCH_COUNT=3.
- STALL high 3 cycles at PC=0x08: PC, INSTR (32'h00100113), FETCH_COUNT frozen; resume -> 32'h0020F1B3 @0x08 next edge.
- BRANCH_TAKEN=1, BRANCH_TARGET=0x1C while PC=0x14: next INSTR=NOP_WORD, INSTR_VALID=0, PC=0x1C; following edge INSTR=32'h0E200FA3 @0x1C.
- BRANCH_TAKEN with STALL=1 and BRANCH_TARGET=0x07: PC=0x04, squash occurs, stall ignored.
- Force PC=0xFC (branch target 0xFC), fetch once: PC wraps to 0x00, INSTR=32'h00000000 (ROM default) @0xFC, valid=1.
- RST pulsed during stall at PC=0x10: next edge PC=0x00, INSTR_VALID=0, FETCH_COUNT=0, state BOOT.
